// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-neuron display path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package snn_pkg;

    // Native width of a firing-rate value as shown on the display.
    localparam int SNN_RATE_W = 8;

    // Segment pattern, bit order gfedcba (bit0 = segment a), active-high.
    typedef logic [6:0] seg7_t;

    // Active-high hex glyphs 0-9, A, b, C, d, E, F.
    localparam seg7_t SEG_HEX [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to 7-segment glyph decoder (active-high, gfedcba).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
//
// Ports:
//   nibble : 4-bit value to display
//   seg    : segment pattern, bit0 = a
module seg7_hex_decoder
    import snn_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/spike_rate_monitor.sv
// Counts spike rising edges per window of enabled cycles and shows a hex digit of the rate.
// Latency: rate/rate_valid 1 cycle after the terminal window cycle; seg 1 cycle after rate/nib_sel.
// Backpressure: none; rate_valid is a one-cycle pulse that is not held for a consumer.
//
// Ports:
//   clk        : clock, all state on rising edge
//   reset      : synchronous, active-high
//   en         : count enable; when low the window stretches and outputs hold
//   spike_in   : spike level from the neuron
//   nib_sel    : 0 = show rate[3:0], 1 = show rate[7:4]
//   rate       : spike count of the last completed window (saturating)
//   rate_valid : one-cycle pulse when rate updates
//   overflow   : last completed window saturated
//   seg        : segment pattern gfedcba, bit0 = a
module spike_rate_monitor
    import snn_pkg::*;
#(
    parameter logic [23:0] WINDOW_CYCLES  = 24'd10_000_000,
    parameter int          CNT_W          = SNN_RATE_W,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             spike_in,
    input  logic             nib_sel,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic             overflow,
    output seg7_t            seg
);

    localparam int               WC_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW_CYCLES - 24'd1);
    localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};
    localparam seg7_t            SEG_XOR = {7{SEG_ACTIVE_LOW}};
    localparam seg7_t            SEG_RST = SEG_HEX[0] ^ SEG_XOR;

    logic [WC_W-1:0]       wcnt;
    logic [CNT_W-1:0]      acc;
    logic                  sat;
    logic                  spike_q;

    logic                  spk_edge;
    logic                  terminal;
    logic                  acc_max;
    logic [CNT_W-1:0]      acc_inc;
    logic [SNN_RATE_W-1:0] rate_ext;
    logic [3:0]            nibble;
    seg7_t                 seg_dec;

    assign spk_edge = spike_in & ~spike_q;
    assign terminal = en & (wcnt == WC_LAST);
    assign acc_max  = (acc == ACC_MAX);
    // Saturating increment; the terminal-cycle edge uses this too so it
    // lands in the window that is closing.
    assign acc_inc  = acc_max ? acc : acc + CNT_W'(1);

    // Narrow counters are zero-extended so the high nibble reads as zero.
    generate
        if (CNT_W >= SNN_RATE_W) begin : g_rate_trunc
            assign rate_ext = rate[SNN_RATE_W-1:0];
        end else begin : g_rate_pad
            assign rate_ext = {{(SNN_RATE_W-CNT_W){1'b0}}, rate};
        end
    endgenerate

    assign nibble = nib_sel ? rate_ext[7:4] : rate_ext[3:0];

    seg7_hex_decoder u_seg_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt       <= '0;
            acc        <= '0;
            sat        <= 1'b0;
            spike_q    <= 1'b0;
            rate       <= '0;
            rate_valid <= 1'b0;
            overflow   <= 1'b0;
            seg        <= SEG_RST;
        end else begin
            // Edge history tracks the input even while disabled, so an edge
            // that happens during en = 0 is consumed and never counted later.
            spike_q    <= spike_in;
            rate_valid <= 1'b0;
            if (en) begin
                if (terminal) begin
                    wcnt       <= '0;
                    acc        <= '0;
                    sat        <= 1'b0;
                    rate       <= spk_edge ? acc_inc : acc;
                    overflow   <= sat | (spk_edge & acc_max);
                    rate_valid <= 1'b1;
                end else begin
                    wcnt <= wcnt + WC_W'(1);
                    if (spk_edge) begin
                        if (acc_max) begin
                            sat <= 1'b1;
                        end else begin
                            acc <= acc_inc;
                        end
                    end
                end
                seg <= seg_dec ^ SEG_XOR;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Self-checking bench for spike_rate_monitor: table of per-window spike patterns
// plus hand sequences for display select, long saturating window, enable gap
// and mid-window reset. Window results are checked through scoreboard queues.
module tb_spike_rate_monitor;
    import snn_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16-cycle window instance
    logic       reset, en, spike_in, nib_sel;
    logic [7:0] rate;
    logic       rate_valid, overflow;
    seg7_t      seg;

    // 1024-cycle window instance
    logic       reset_b, en_b, spike_b, nib_sel_b;
    logic [7:0] rate_b;
    logic       rate_valid_b, overflow_b;
    seg7_t      seg_b;

    spike_rate_monitor #(
        .WINDOW_CYCLES  (24'd16),
        .CNT_W          (8),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .spike_in   (spike_in),
        .nib_sel    (nib_sel),
        .rate       (rate),
        .rate_valid (rate_valid),
        .overflow   (overflow),
        .seg        (seg)
    );

    spike_rate_monitor #(
        .WINDOW_CYCLES  (24'd1024),
        .CNT_W          (8),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut_big (
        .clk        (clk),
        .reset      (reset_b),
        .en         (en_b),
        .spike_in   (spike_b),
        .nib_sel    (nib_sel_b),
        .rate       (rate_b),
        .rate_valid (rate_valid_b),
        .overflow   (overflow_b),
        .seg        (seg_b)
    );

    typedef struct {
        logic [7:0] rate;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [15:0] pat;
        logic [7:0]  exp_rate;
        seg7_t       exp_seg;
    } vec_t;

    exp_t sb_q[$];
    exp_t sb_big_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;
    int pulses = 0;
    int pulses_b = 0;
    int last_valid_cyc = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit big, input logic [7:0] r, input logic o);
        exp_t e;
        e.rate = r;
        e.ovf  = o;
        if (big) sb_big_q.push_back(e);
        else     sb_q.push_back(e);
    endtask

    // One clock cycle of stimulus for the 16-cycle instance.
    task automatic step(input logic r, input logic s, input logic e);
        @(negedge clk);
        reset    = r;
        spike_in = s;
        en       = e;
    endtask

    always @(negedge clk) begin : mon_small
        exp_t e;
        if (rate_valid === 1'b1) begin
            pulses++;
            last_valid_cyc = cyc_cnt;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got rate 0x%0h with no window pending", rate);
            end else begin
                e = sb_q.pop_front();
                chk("win_rate", 32'(rate), 32'(e.rate));
                chk("win_overflow", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin : mon_big
        exp_t e;
        if (rate_valid_b === 1'b1) begin
            pulses_b++;
            if (sb_big_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse_big: got rate 0x%0h with no window pending", rate_b);
            end else begin
                e = sb_big_q.pop_front();
                chk("big_rate", 32'(rate_b), 32'(e.rate));
                chk("big_overflow", 32'(overflow_b), 32'(e.ovf));
            end
        end
    end

    initial begin
        vec_t        tbl [10];
        logic [15:0] pat;
        int          c0;

        tbl[0] = '{16'h0000, 8'd0, 7'h3F};
        tbl[1] = '{16'h0155, 8'd5, 7'h6D};
        tbl[2] = '{16'h83FF, 8'd2, 7'h5B};
        tbl[3] = '{16'h0000, 8'd0, 7'h3F};
        tbl[4] = '{16'hFFFF, 8'd1, 7'h06};
        tbl[5] = '{16'hFFFF, 8'd0, 7'h3F};
        tbl[6] = '{16'hAAAA, 8'd8, 7'h7F};
        tbl[7] = '{16'h5555, 8'd7, 7'h07};
        tbl[8] = '{16'h8001, 8'd2, 7'h5B};
        tbl[9] = '{16'h0000, 8'd0, 7'h3F};

        reset     = 1'b1;
        en        = 1'b1;
        spike_in  = 1'b0;
        nib_sel   = 1'b0;
        reset_b   = 1'b1;
        en_b      = 1'b1;
        spike_b   = 1'b0;
        nib_sel_b = 1'b0;

        // Reset held for 3 cycles
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("rst_rate", 32'(rate), 32'd0);
        chk("rst_valid", 32'(rate_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_seg", 32'(seg), 32'h3F);

        // Back-to-back windows from the table
        for (int w = 0; w < 10; w++) begin
            push_exp(1'b0, tbl[w].exp_rate, 1'b0);
            for (int i = 0; i < 16; i++) begin
                step(1'b0, tbl[w].pat[i], 1'b1);
                if (w > 0 && i == 1) begin
                    chk("tbl_seg", 32'(seg), 32'(tbl[w-1].exp_seg));
                    if (w == 1) chk("first_window_single_pulse", 32'(pulses), 32'd1);
                end
            end
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("tbl_pulse_count", 32'(pulses), 32'd10);

        // Display select: rate 5, low nibble then high nibble
        pat = 16'h0155;
        push_exp(1'b0, 8'd5, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, pat[i], 1'b1);
        push_exp(1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("nib_rate", 32'(rate), 32'd5);
        chk("nib_valid", 32'(rate_valid), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("nib_valid_drop", 32'(rate_valid), 32'd0);
        chk("nib_seg_lo", 32'(seg), 32'h6D);
        nib_sel = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        chk("nib_seg_hi", 32'(seg), 32'h3F);
        nib_sel = 1'b0;
        for (int i = 3; i < 16; i++) step(1'b0, 1'b0, 1'b1);

        // Enable gap of 20 cycles: 3 spikes lost inside, 2 counted outside
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        c0 = 0;
        push_exp(1'b0, 8'd2, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, (k == 2 || k == 10), 1'b1);
            if (k == 0) c0 = cyc_cnt;
            if (k == 5) begin
                for (int g = 0; g < 20; g++) step(1'b0, (g == 3 || g == 8 || g == 13), 1'b0);
            end
        end

        // Mid-window reset at wcnt = 9 with four edges accumulated
        for (int k = 0; k < 9; k++) begin
            step(1'b0, (k == 0 || k == 2 || k == 4 || k == 6), 1'b1);
            if (k == 1) chk("gap_latency", 32'(last_valid_cyc - c0), 32'd36);
            if (k == 2) chk("pre_reset_seg", 32'(seg), 32'h5B);
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("midrst_rate", 32'(rate), 32'd0);
        chk("midrst_valid", 32'(rate_valid), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        chk("midrst_seg", 32'(seg), 32'h3F);
        push_exp(1'b0, 8'd3, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, (k == 1 || k == 5 || k == 9), 1'b1);
            if (k == 0) c0 = cyc_cnt;
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("midrst_latency", 32'(last_valid_cyc - c0), 32'd16);

        // 1024-cycle window, toggling input saturates, then a clean window
        push_exp(1'b1, 8'd255, 1'b1);
        for (int k = 0; k < 1024; k++) begin
            step(1'b1, 1'b0, 1'b1);
            reset_b = 1'b0;
            spike_b = (k % 2 == 0);
        end
        push_exp(1'b1, 8'd0, 1'b0);
        for (int k = 0; k < 1024; k++) begin
            step(1'b1, 1'b0, 1'b1);
            spike_b = 1'b0;
            if (k == 2) chk("big_seg_sat", 32'(seg_b), 32'h71);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b1);
            reset_b = 1'b1;
        end

        chk("small_sb_drained", 32'(sb_q.size()), 32'd0);
        chk("big_sb_drained", 32'(sb_big_q.size()), 32'd0);
        chk("small_pulse_total", 32'(pulses), 32'd14);
        chk("big_pulse_total", 32'(pulses_b), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
